// File: rtl/mem_wb_writeback.sv
// ----------------------------------------------------------------------------
// mem_wb_writeback
//
// MEM/WB pipeline stage of the 16-bit pipelined core. The stage registers the
// memory-stage result and drives the register file write port (register ID,
// write enable and write data). It also stops the core when an HLT retires
// and counts retired instructions.
//
// Optional build macro:
//   WB_R0_ZERO_EN - when defined, writes to register 0 are suppressed, which
//                   makes R0 a hard-wired zero register. When undefined, R0
//                   is writable like any other register.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   mem_valid      in   MEM stage holds a real instruction (0 = bubble)
//   mem_reg_id     in   destination register of the MEM instruction
//   mem_reg_write  in   instruction writes a register
//   mem_to_reg     in   writeback source is load data
//   mem_pcs        in   writeback source is PC+2 (PCS instruction)
//   mem_halt       in   instruction is HLT
//   mem_alu_result in   ALU result
//   mem_rdata      in   data-memory read data
//   mem_pc_plus2   in   PC+2 of the instruction
//   stall          in   hold WB register contents
//   flush          in   load a bubble into WB
//   wb_reg_id      out  register ID to the write decoder
//   wb_write_reg   out  register write enable to the write decoder
//   wb_data        out  register write data
//   wb_fwd_valid   out  WB holds a forwardable write (same as wb_write_reg)
//   halted         out  HLT has retired; core stopped
//   retired_cnt    out  count of retired valid instructions
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_wb_writeback #(
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic [RW-1:0]    mem_reg_id,
    input  logic             mem_reg_write,
    input  logic             mem_to_reg,
    input  logic             mem_pcs,
    input  logic             mem_halt,
    input  logic [DW-1:0]    mem_alu_result,
    input  logic [DW-1:0]    mem_rdata,
    input  logic [DW-1:0]    mem_pc_plus2,
    input  logic             stall,
    input  logic             flush,
    output logic [RW-1:0]    wb_reg_id,
    output logic             wb_write_reg,
    output logic [DW-1:0]    wb_data,
    output logic             wb_fwd_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

    wb_state_t state;
    wb_state_t state_next;

    // WB stage registers
    logic          wb_valid;
    logic          wb_reg_write;
    logic          wb_mem_to_reg;
    logic          wb_pcs;
    logic          wb_halt;
    logic [DW-1:0] wb_alu_result;
    logic [DW-1:0] wb_rdata;
    logic [DW-1:0] wb_pc_plus2;

    logic running;
    logic write_base;
    logic count_en;

    // Pipeline register capture. Flush outranks stall; on a flush only the
    // valid bit matters, so the payload fields are simply left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_reg_id     <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_pcs        <= 1'b0;
            wb_halt       <= 1'b0;
            wb_alu_result <= '0;
            wb_rdata      <= '0;
            wb_pc_plus2   <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid      <= mem_valid;
            wb_reg_id     <= mem_reg_id;
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_pcs        <= mem_pcs;
            wb_halt       <= mem_halt;
            wb_alu_result <= mem_alu_result;
            wb_rdata      <= mem_rdata;
            wb_pc_plus2   <= mem_pc_plus2;
        end
    end

    // Run/halt state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. HALTED is sticky until reset, and stall/flush have
    // no influence on the state.
    always_comb begin
        state_next = state;
        running    = 1'b0;
        case (state)
            RUN: begin
                running = 1'b1;
                if (wb_valid && wb_halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign halted = (state == HALTED);

    // Writeback source select: PC+2 wins over load data, which wins over the
    // ALU result.
    always_comb begin
        wb_data = wb_alu_result;
        if (wb_pcs) begin
            wb_data = wb_pc_plus2;
        end else if (wb_mem_to_reg) begin
            wb_data = wb_rdata;
        end
    end

    // An HLT sitting in WB never writes, even if its reg_write bit is set.
    assign write_base = wb_valid & wb_reg_write & ~wb_halt & running;

`ifdef WB_R0_ZERO_EN
    assign wb_write_reg = write_base & (wb_reg_id != '0);
`else
    assign wb_write_reg = write_base;
`endif

    assign wb_fwd_valid = wb_write_reg;

    // Retire counting. The edge on which an HLT in WB moves the FSM to HALTED
    // is treated as already stopped, so the instruction captured behind the
    // HLT is not counted; the HLT itself was counted when it was captured.
    always_comb begin
        count_en = running & ~stall & ~flush & mem_valid & ~(wb_valid & wb_halt);
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (count_en) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// ----------------------------------------------------------------------------
// tb_mem_wb_writeback
//
// Directed testbench for mem_wb_writeback. The stimulus process drives one MEM
// instruction per cycle and pushes the hand-computed WB outputs expected after
// the next rising edge, tagged with the cycle they belong to. A monitor on the
// falling edge pops each entry when its cycle arrives and compares it against
// the DUT outputs.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_wb_writeback;

    localparam int DW    = 16;
    localparam int RW    = 4;
    localparam int CNT_W = 16;

`ifdef WB_R0_ZERO_EN
    localparam logic R0_WR = 1'b0;
`else
    localparam logic R0_WR = 1'b1;
`endif

    logic             clk;
    logic             rst_n;
    logic             mem_valid;
    logic [RW-1:0]    mem_reg_id;
    logic             mem_reg_write;
    logic             mem_to_reg;
    logic             mem_pcs;
    logic             mem_halt;
    logic [DW-1:0]    mem_alu_result;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    mem_pc_plus2;
    logic             stall;
    logic             flush;
    logic [RW-1:0]    wb_reg_id;
    logic             wb_write_reg;
    logic [DW-1:0]    wb_data;
    logic             wb_fwd_valid;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;

    typedef struct {
        int               tag;
        string            name;
        logic [RW-1:0]    id;
        logic             chk_id;
        logic             wr;
        logic [DW-1:0]    data;
        logic             chk_data;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mem_wb_writeback #(
        .DW    (DW),
        .RW    (RW),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_reg_id     (mem_reg_id),
        .mem_reg_write  (mem_reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_pcs        (mem_pcs),
        .mem_halt       (mem_halt),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_pc_plus2   (mem_pc_plus2),
        .stall          (stall),
        .flush          (flush),
        .wb_reg_id      (wb_reg_id),
        .wb_write_reg   (wb_write_reg),
        .wb_data        (wb_data),
        .wb_fwd_valid   (wb_fwd_valid),
        .halted         (halted),
        .retired_cnt    (retired_cnt)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to tag scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    // Compares the DUT outputs with one expected set; one check per field.
    task automatic checkOutput(input string name, input logic [RW-1:0] id,
                               input logic chk_id, input logic wr,
                               input logic [DW-1:0] data, input logic chk_data,
                               input logic hlt, input logic [CNT_W-1:0] cnt);
        checks++;
        if (wb_write_reg !== wr) begin
            errors++;
            $display("[TB] FAIL %s wb_write_reg actual=%0b required=%0b", name, wb_write_reg, wr);
        end
        checks++;
        if (wb_fwd_valid !== wr) begin
            errors++;
            $display("[TB] FAIL %s wb_fwd_valid actual=%0b required=%0b", name, wb_fwd_valid, wr);
        end
        checks++;
        if (halted !== hlt) begin
            errors++;
            $display("[TB] FAIL %s halted actual=%0b required=%0b", name, halted, hlt);
        end
        checks++;
        if (retired_cnt !== cnt) begin
            errors++;
            $display("[TB] FAIL %s retired_cnt actual=%h required=%h", name, retired_cnt, cnt);
        end
        if (chk_id) begin
            checks++;
            if (wb_reg_id !== id) begin
                errors++;
                $display("[TB] FAIL %s wb_reg_id actual=%0d required=%0d", name, wb_reg_id, id);
            end
        end
        if (chk_data) begin
            checks++;
            if (wb_data !== data) begin
                errors++;
                $display("[TB] FAIL %s wb_data actual=%h required=%h", name, wb_data, data);
            end
        end
    endtask

    // Drives one MEM-stage instruction plus stall/flush on the falling edge.
    task automatic applyStimulus(input logic v, input logic [RW-1:0] id,
                                 input logic rw, input logic m2r,
                                 input logic pcs, input logic hlt,
                                 input logic [DW-1:0] alu,
                                 input logic [DW-1:0] rdata,
                                 input logic [DW-1:0] pc2,
                                 input logic st, input logic fl);
        @(negedge clk);
        mem_valid      = v;
        mem_reg_id     = id;
        mem_reg_write  = rw;
        mem_to_reg     = m2r;
        mem_pcs        = pcs;
        mem_halt       = hlt;
        mem_alu_result = alu;
        mem_rdata      = rdata;
        mem_pc_plus2   = pc2;
        stall          = st;
        flush          = fl;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Queues the outputs expected after the next rising edge.
    task automatic expectOut(input string name, input logic [RW-1:0] id,
                             input logic chk_id, input logic wr,
                             input logic [DW-1:0] data, input logic chk_data,
                             input logic hlt, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.tag      = cyc + 1;
        e.name     = name;
        e.id       = id;
        e.chk_id   = chk_id;
        e.wr       = wr;
        e.data     = data;
        e.chk_data = chk_data;
        e.hlt      = hlt;
        e.cnt      = cnt;
        sb.push_back(e);
    endtask

    // Asserts reset away from the clock edge and checks the cleared outputs
    // immediately, before any clock edge occurs.
    task automatic doReset(input string name);
        rst_n = 1'b0;
        #1;
        checkOutput(name, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops entries whose cycle has arrived and compares.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.tag < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s stale entry actual_cycle=%0d required_cycle=%0d", e.name, cyc, e.tag);
            end else begin
                checkOutput(e.name, e.id, e.chk_id, e.wr, e.data, e.chk_data, e.hlt, e.cnt);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        rst_n          = 1'b1;
        mem_valid      = 1'b0;
        mem_reg_id     = '0;
        mem_reg_write  = 1'b0;
        mem_to_reg     = 1'b0;
        mem_pcs        = 1'b0;
        mem_halt       = 1'b0;
        mem_alu_result = '0;
        mem_rdata      = '0;
        mem_pc_plus2   = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        #2;
        doReset("reset_init");

        // ALU write to R5
        applyStimulus(1, 4'd5, 1, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0);
        expectOut("alu_write", 4'd5, 1, 1, 16'h1234, 1, 0, 16'd1);

        // Source select: load, PCS, PCS overriding load
        applyStimulus(1, 4'd1, 1, 1, 0, 0, 16'h5555, 16'h00AA, 16'h7777, 0, 0);
        expectOut("src_load", 4'd1, 1, 1, 16'h00AA, 1, 0, 16'd2);
        applyStimulus(1, 4'd2, 1, 0, 1, 0, 16'h5555, 16'h6666, 16'h0102, 0, 0);
        expectOut("src_pcs", 4'd2, 1, 1, 16'h0102, 1, 0, 16'd3);
        applyStimulus(1, 4'd4, 1, 1, 1, 0, 16'h5555, 16'h00AA, 16'h0102, 0, 0);
        expectOut("src_pcs_over_load", 4'd4, 1, 1, 16'h0102, 1, 0, 16'd4);

        // Bubble: no write, no count, id/data still registered
        applyStimulus(0, 4'd6, 1, 0, 0, 0, 16'h9999, 16'h0000, 16'h0000, 0, 0);
        expectOut("bubble", 4'd6, 1, 0, 16'h9999, 1, 0, 16'd4);

        // Valid instruction that does not write a register
        applyStimulus(1, 4'd8, 0, 0, 0, 0, 16'h0F0F, 16'h0000, 16'h0000, 0, 0);
        expectOut("no_reg_write", 4'd8, 1, 0, 16'h0F0F, 1, 0, 16'd5);

        // Stall holds R3 for two cycles, then flush (with stall) bubbles WB
        applyStimulus(1, 4'd3, 1, 0, 0, 0, 16'h3333, 16'h0000, 16'h0000, 0, 0);
        expectOut("capture_r3", 4'd3, 1, 1, 16'h3333, 1, 0, 16'd6);
        applyStimulus(1, 4'd9, 1, 0, 0, 0, 16'hBEEF, 16'h0000, 16'h0000, 1, 0);
        expectOut("stall_hold_1", 4'd3, 1, 1, 16'h3333, 1, 0, 16'd6);
        applyStimulus(1, 4'd10, 1, 0, 0, 0, 16'hCAFE, 16'h0000, 16'h0000, 1, 0);
        expectOut("stall_hold_2", 4'd3, 1, 1, 16'h3333, 1, 0, 16'd6);
        applyStimulus(1, 4'd11, 1, 0, 0, 0, 16'hDEAD, 16'h0000, 16'h0000, 1, 1);
        expectOut("flush_over_stall", 4'd0, 0, 0, 16'h0000, 0, 0, 16'd6);
        applyStimulus(1, 4'd12, 1, 0, 0, 0, 16'h0C0C, 16'h0000, 16'h0000, 0, 0);
        expectOut("after_flush", 4'd12, 1, 1, 16'h0C0C, 1, 0, 16'd7);

        // Write to R0; enable depends on the build option
        applyStimulus(1, 4'd0, 1, 0, 0, 0, 16'h00F0, 16'h0000, 16'h0000, 0, 0);
        expectOut("r0_write", 4'd0, 1, R0_WR, 16'h00F0, 1, 0, 16'd8);

        // Valid write in WB, then asynchronous reset between clock edges
        applyStimulus(1, 4'd14, 1, 0, 0, 0, 16'hABCD, 16'h0000, 16'h0000, 0, 0);
        expectOut("pre_reset_write", 4'd14, 1, 1, 16'hABCD, 1, 0, 16'd9);
        applyIdle();
        #2;
        doReset("reset_mid_cycle");

        // Halt: HLT (with reg_write set) followed by writes to R7
        applyStimulus(1, 4'd1, 1, 0, 0, 0, 16'h1111, 16'h0000, 16'h0000, 0, 0);
        expectOut("pre_halt_write", 4'd1, 1, 1, 16'h1111, 1, 0, 16'd1);
        applyStimulus(1, 4'd13, 1, 0, 0, 1, 16'h2222, 16'h0000, 16'h0000, 0, 0);
        expectOut("hlt_in_wb", 4'd13, 1, 0, 16'h2222, 1, 0, 16'd2);
        applyStimulus(1, 4'd7, 1, 0, 0, 0, 16'h7777, 16'h0000, 16'h0000, 0, 0);
        expectOut("halted_r7_blocked", 4'd7, 1, 0, 16'h7777, 1, 1, 16'd2);
        applyStimulus(1, 4'd7, 1, 0, 0, 0, 16'h7778, 16'h0000, 16'h0000, 0, 0);
        expectOut("halted_sticky", 4'd7, 1, 0, 16'h7778, 1, 1, 16'd2);
        applyStimulus(1, 4'd7, 1, 0, 0, 0, 16'h7779, 16'h0000, 16'h0000, 1, 1);
        expectOut("halted_ignores_flush", 4'd0, 0, 0, 16'h0000, 0, 1, 16'd2);
        applyIdle();
        #2;
        doReset("reset_after_halt");

        // Counter wrap: 65535 retirements reach 0xFFFF, one more wraps to 0
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(1, 4'd1, 0, 0, 0, 0, 16'(i), 16'h0000, 16'h0000, 0, 0);
            if (i == 65534) begin
                expectOut("cnt_ffff", 4'd1, 1, 0, 16'hFFFE, 1, 0, 16'hFFFF);
            end
        end
        applyStimulus(1, 4'd1, 0, 0, 0, 0, 16'hAAAA, 16'h0000, 16'h0000, 0, 0);
        expectOut("cnt_wrap", 4'd1, 1, 0, 16'hAAAA, 1, 0, 16'h0000);
        applyIdle();

        // Let the monitor drain the scoreboard, bounded
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline stage of the 16-bit pipelined core.
- Latches the memory-stage result and selects writeback data from ALU result, load data or PC+2 (PCS).
- Directly drives the register file write port: register ID, write enable and write data feed the 4-to-16 write decoder and the data bus.
- Also tracks HLT retirement and counts retired instructions.

Parameters:
- DW, 16, data width of results and writeback bus
- RW, 4, register ID width (16 registers)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_valid  input  1  MEM stage holds a real instruction (0 = bubble)
- mem_reg_id  input  RW  destination register of MEM instruction
- mem_reg_write  input  1  instruction writes a register
- mem_to_reg  input  1  writeback source is load data
- mem_pcs  input  1  writeback source is PC+2 (PCS instruction)
- mem_halt  input  1  instruction is HLT
- mem_alu_result  input  DW  ALU result
- mem_rdata  input  DW  data-memory read data
- mem_pc_plus2  input  DW  PC+2 of instruction
- stall  input  1  hold WB register contents
- flush  input  1  load bubble into WB
- wb_reg_id  output  RW  register ID to write decoder
- wb_write_reg  output  1  register write enable to write decoder
- wb_data  output  DW  register write data
- wb_fwd_valid  output  1  WB holds a forwardable write (same as wb_write_reg)
- halted  output  1  HLT has retired; core stopped
- retired_cnt  output  CNT_W  count of retired valid instructions

Behaviour:
- Reset (rst_n low, async): all WB stage registers cleared.
  - wb_valid=0, wb_reg_id=0, wb_write_reg=0, wb_data=0, wb_fwd_valid=0, halted=0, retired_cnt=0.
  - FSM enters RUN.
  - Reset asserted mid-operation discards the in-flight WB instruction; no write occurs in the reset cycle.
- Capture at each rising edge, priority order:
  - 1. flush=1: wb_valid <= 0. Other fields don't-care. Flush beats stall.
  - 2. stall=1: all WB registers hold.
  - 3. Otherwise: wb_valid <= mem_valid, and every mem_* field is registered.
- Latency: exactly 1 cycle from MEM inputs to WB outputs.
- wb_data: combinational mux of registered fields.
  - pcs=1 -> pc_plus2; else mem_to_reg=1 -> rdata; else alu_result.
  - pcs wins if both pcs and mem_to_reg are set.
- wb_write_reg = wb_valid & reg_write & (state==RUN).
- wb_reg_id is driven from the register regardless of the enable.
- A held (stalled) instruction keeps wb_write_reg asserted every held cycle; rewriting the same value is harmless.
- FSM:
  - RUN: when wb_valid & halt is true at a clock edge -> HALTED. A HLT in WB never writes a register.
  - HALTED: sticky until reset. halted=1, wb_write_reg=0. stall and flush are ignored for state.
- retired_cnt:
  - Increments by 1 on an edge where state==RUN, stall=0, flush=0 and mem_valid=1 (new valid instruction captured).
  - The HLT itself is counted.
  - Wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
  - Frozen in HALTED.
- Bubbles (mem_valid=0) never write and never count.

Optional Feature:
- Macro: WB_R0_ZERO_EN.
- Defined: wb_write_reg is additionally gated by wb_reg_id != 0, so R0 is never written. wb_fwd_valid is gated the same way.
- Undefined: R0 is writable like any other register.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a valid write in WB -> all outputs 0 immediately; state RUN.
- ALU write: mem_valid=1, reg_id=5, reg_write=1, alu_result=0x1234, no stall/flush -> next cycle wb_reg_id=5, wb_write_reg=1, wb_data=0x1234, retired_cnt=1.
- Source select, three back-to-back instructions -> wb_data=0x00AA, 0x0102, 0x0102:
  - mem_to_reg=1, rdata=0x00AA.
  - pcs=1, pc_plus2=0x0102.
  - pcs=1 and mem_to_reg=1.
- Stall/flush: capture reg 3, then stall=1 for 2 cycles with new MEM inputs -> outputs hold reg 3 and retired_cnt unchanged. Then flush=1 with stall=1 -> wb_write_reg=0 next cycle.
- Halt: HLT captured followed by a valid write to reg 7 -> halted=1 one cycle after HLT is in WB, and reg 7 is never written. retired_cnt counts HLT but not later instructions.
- Wrap and R0: preload counter to 0xFFFF, retire one -> 0x0000. With WB_R0_ZERO_EN defined, a write to reg 0 gives wb_write_reg=0; undefined gives 1.
